// File: rtl/debug_reg_dump.sv
// Debug register dump engine: walks a register bank through its debug index
// and streams every register MSByte-first to a byte-wide valid/ready transmitter.
module debug_reg_dump #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_reg_debug,
  output logic                  o_debug_step,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned RCW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned BCW   = $clog2(BYTES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEND,
    S_STEP,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [RCW-1:0]        r_reg_cnt;
  logic [BCW-1:0]        r_byte_cnt;
  logic                  r_debug_step;
  logic                  r_tx_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_xfer;
  logic                  w_last_byte;
  logic                  w_last_reg;

  assign w_xfer      = (r_state == S_SEND) && i_tx_ready;
  assign w_last_byte = (r_byte_cnt == BCW'(BYTES - 1));
  assign w_last_reg  = (r_reg_cnt == RCW'(NUM_REGS - 1));

  // Next-state decode; i_start only matters in IDLE, i_tx_ready only in SEND.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SEND;
      S_SEND:    if (w_xfer && w_last_byte) w_next = S_STEP;
      S_STEP:    w_next = w_last_reg ? S_DONE : S_SETTLE;
      S_SETTLE:  w_next = S_CAPTURE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Control outputs registered from the next state so they line up with it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_debug_step <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_debug_step <= (w_next == S_STEP);
      r_tx_valid   <= (w_next == S_SEND);
      r_busy       <= (w_next != S_IDLE);
      r_done       <= (w_next == S_DONE);
    end
  end

  // Shift register and counters; shift only on an accepted byte so data holds under stall.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_reg_cnt  <= '0;
    end else begin
      case (r_state)
        S_CAPTURE: begin
          r_shift    <= i_reg_debug;
          r_byte_cnt <= '0;
        end
        S_SEND: begin
          if (w_xfer) begin
            r_shift    <= {r_shift[DATA_WIDTH-9:0], 8'h00};
            r_byte_cnt <= r_byte_cnt + BCW'(1);
          end
        end
        S_STEP: begin
          // The last register leaves the counter at 0 rather than wrapping past it.
          if (w_last_reg) r_reg_cnt <= '0;
          else            r_reg_cnt <= r_reg_cnt + RCW'(1);
        end
        S_DONE:  r_reg_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign o_debug_step = r_debug_step;
  assign o_tx_valid   = r_tx_valid;
  assign o_tx_data    = r_shift[DATA_WIDTH-1 -: 8];
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_debug_reg_dump.sv
// Directed bench for debug_reg_dump with a negedge-updating register bank model.
module tb_debug_reg_dump;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned NBYTES = NR * DW / 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] reg_debug;
  logic          o_debug_step;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          ready;
  logic          o_busy;
  logic          o_done;

  int total;
  int bad;

  logic [DW-1:0] bank [NR];
  logic [4:0]    idx;

  byte unsigned  bytes[$];
  int            step_cnt;
  int            done_cnt;
  int            done_cyc;
  int            cyc;
  bit            stall_prev;
  logic [7:0]    prev_data;

  debug_reg_dump #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_reg_debug  (reg_debug),
    .o_debug_step (o_debug_step),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: debug index advances on negedge, reset by the same net as the DUT.
  always @(negedge clk or posedge rst) begin
    if (rst) idx <= '0;
    else if (o_debug_step) idx <= idx + 5'd1;
  end
  assign reg_debug = bank[idx];

  // Cycle monitor: records the byte stream and checks per-cycle invariants.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      cyc = 0;
    end else begin
      total++;
      if ($countones({o_debug_step, o_tx_valid, o_done}) > 1) begin
        bad++;
        $display("FAIL excl t=%0t step=%b valid=%b done=%b", $time, o_debug_step, o_tx_valid, o_done);
      end
      total++;
      if (!o_busy && (o_tx_valid || o_debug_step || o_done)) begin
        bad++;
        $display("FAIL busy_idle t=%0t busy=0 valid=%b step=%b done=%b", $time, o_tx_valid, o_debug_step, o_done);
      end
      if (stall_prev) begin
        total++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== prev_data) begin
          bad++;
          $display("FAIL hold t=%0t valid=%b data=%h required valid=1 data=%h", $time, o_tx_valid, o_tx_data, prev_data);
        end
      end
      stall_prev = o_tx_valid && !ready;
      prev_data  = o_tx_data;
      if (o_tx_valid && ready) bytes.push_back(o_tx_data);
      if (o_debug_step) step_cnt++;
      cyc = o_busy ? cyc + 1 : 0;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int k);
    logic [DW-1:0] v;
    v = bank[k / 4];
    return v[8*(3 - (k % 4)) +: 8];
  endfunction

  task automatic run_dump(input bit bp, input bit spam);
    bytes.delete();
    step_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    @(posedge clk); #1;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      if (bp) ready = 1'($urandom_range(0, 1));
      if (spam) start = (i % 7 == 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready = 1'b1;
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("FAIL dump_timeout done_cnt=0 required 1");
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string name);
    int errs;
    errs = 0;
    total++;
    if (bytes.size() != NBYTES) begin
      bad++;
      $display("FAIL %s_count got=%0d required=%0d", name, bytes.size(), NBYTES);
    end else begin
      for (int k = 0; k < NBYTES; k++) if (bytes[k] !== exp_byte(k)) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL %s_stream mismatching_bytes=%0d required=0", name, errs);
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s_done got=%0d required=1", name, done_cnt);
    end
    total++;
    if (step_cnt != NR) begin
      bad++;
      $display("FAIL %s_steps got=%0d required=%0d", name, step_cnt, NR);
    end
    total++;
    if (idx !== 5'd0) begin
      bad++;
      $display("FAIL %s_bank_idx got=%0d required=0", name, idx);
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_after busy=%b required=0", name, o_busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_busy, o_tx_valid, o_debug_step, o_done, o_tx_data} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b valid=%b step=%b done=%b data=%h required all 0",
               o_busy, o_tx_valid, o_debug_step, o_done, o_tx_data);
    end
    rst = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b valid=%b required 0 0", o_busy, o_tx_valid);
    end
  endtask

  task automatic test_basic_dump;
    logic [7:0] spot [16];
    int         pos  [16];
    spot = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
             8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h01, 8'h00};
    pos  = '{4, 5, 6, 7, 8, 9, 10, 11, 40, 41, 42, 43, 124, 125, 126, 127};
    run_dump(1'b0, 1'b0);
    check_stream("basic");
    for (int i = 0; i < 16; i++) begin
      if (bytes.size() > pos[i]) begin
        total++;
        if (bytes[pos[i]] !== spot[i]) begin
          bad++;
          $display("FAIL basic_byte%0d got=%h required=%h", pos[i], bytes[pos[i]], spot[i]);
        end
      end
    end
    total++;
    if (done_cyc != 224) begin
      bad++;
      $display("FAIL basic_latency done_cycle=%0d required=224", done_cyc);
    end
  endtask

  task automatic test_backpressure;
    run_dump(1'b1, 1'b0);
    check_stream("bp");
  endtask

  task automatic test_back_to_back;
    run_dump(1'b0, 1'b1);
    check_stream("spam");
    run_dump(1'b0, 1'b0);
    check_stream("second");
  endtask

  task automatic test_reset_mid_dump;
    bytes.delete();
    step_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 500 && bytes.size() < 50; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (bytes.size() < 50) begin
      bad++;
      $display("FAIL abort_reach50 got=%0d required>=50", bytes.size());
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({o_busy, o_tx_valid, o_debug_step, o_done, o_tx_data} !== 12'h000 || idx !== 5'd0) begin
      bad++;
      $display("FAIL abort_async got busy=%b valid=%b step=%b done=%b data=%h idx=%0d required all 0",
               o_busy, o_tx_valid, o_debug_step, o_done, o_tx_data, idx);
    end
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL abort_no_done got=%0d required=0", done_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_dump(1'b0, 1'b0);
    check_stream("after_abort");
    if (bytes.size() >= 4) begin
      total++;
      if ({bytes[0], bytes[1], bytes[2], bytes[3]} !== 32'h0) begin
        bad++;
        $display("FAIL after_abort_r0 got=%h%h%h%h required=00000000", bytes[0], bytes[1], bytes[2], bytes[3]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    step_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    cyc = 0;
    stall_prev = 1'b0;
    prev_data = '0;
    for (int i = 0; i < NR; i++) bank[i] = '0;
    bank[1]  = 32'd1;
    bank[2]  = 32'd2;
    bank[10] = 32'd4;
    bank[31] = 32'd256;
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;

    test_reset();
    test_basic_dump();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_dump();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
